// File: rtl/pll_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module   : pll_reset_seq
//  Purpose  : Reset/lock sequencer downstream of the core PLL. Pulses the PLL
//             reset, waits for a stable (synchronized) lock with a timeout and
//             bounded retries, holds the core reset for a settle period, and
//             drops back to waiting whenever lock is lost.
//  Revision : 1.0 - initial release
// ============================================================================
module pll_reset_seq #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_STABLE    = 1024,
    parameter int unsigned HOLD_CYCLES    = 4096,
    parameter int unsigned LOCK_TIMEOUT   = 1000000,
    parameter int unsigned MAX_RETRIES    = 8,
    parameter int unsigned CNT_W          = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked_i,
    output logic       pll_rst_o,
    output logic       sys_reset_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic [7:0] loss_count_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_PLLRST    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_pll_rst_cycles = CNT_W'(PLL_RST_CYCLES);
    localparam logic [CNT_W-1:0] c_lock_stable    = CNT_W'(LOCK_STABLE);
    localparam logic [CNT_W-1:0] c_hold_cycles    = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] c_lock_timeout   = CNT_W'(LOCK_TIMEOUT);
    localparam logic [7:0]       c_max_retries    = 8'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] c_cnt_one        = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;       // pulse / timeout / hold counter
    logic [CNT_W-1:0] stab_q, stab_d;     // consecutive locked_s-high counter
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             sync1_q, sync2_q;
    logic             pll_rst_q, sys_reset_q, ready_q, fail_q;

    logic             locked_s;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] stab_inc;
    logic [7:0]       retry_inc;
    logic [7:0]       loss_sat;

    assign locked_s  = sync2_q;
    assign cnt_inc   = cnt_q + c_cnt_one;
    assign stab_inc  = stab_q + c_cnt_one;
    assign retry_inc = retry_q + 8'd1;
    assign loss_sat  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= locked_i;
            sync2_q <= sync1_q;
        end
    end

    // Next-state, counter and retry/loss bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stab_d  = '0;
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            ST_PLLRST: begin
                // The entering edge already counts as the first pulse clock.
                if (cnt_q == c_pll_rst_cycles) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT_LOCK: begin
                stab_d = locked_s ? stab_inc : '0;
                cnt_d  = cnt_inc;
                // Lock acceptance is checked first so it wins over a timeout.
                if (locked_s && (stab_inc == c_lock_stable)) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    stab_d  = '0;
                end else if (cnt_inc == c_lock_timeout) begin
                    retry_d = retry_inc;
                    stab_d  = '0;
                    if (retry_inc == c_max_retries) begin
                        state_d = ST_FAIL;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_PLLRST;
                        cnt_d   = c_cnt_one;
                    end
                end
            end
            ST_HOLD: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    loss_d  = loss_sat;
                end else if (cnt_inc == c_hold_cycles) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RUN: begin
                retry_d = '0;
                cnt_d   = '0;
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    loss_d  = loss_sat;
                end
            end
            ST_FAIL: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_PLLRST;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PLLRST;
            cnt_q       <= '0;
            stab_q      <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b0;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stab_q      <= stab_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= (state_d == ST_PLLRST);
            sys_reset_q <= (state_d != ST_RUN);
            ready_q     <= (state_d == ST_RUN);
            fail_q      <= (state_d == ST_FAIL);
        end
    end

    assign pll_rst_o    = pll_rst_q;
    assign sys_reset_o  = sys_reset_q;
    assign ready_o      = ready_q;
    assign fail_o       = fail_q;
    assign loss_count_o = loss_q;
    assign state_o      = state_q;

endmodule
`default_nettype wire
